// File: rtl/cpu_prog_loader.sv
// cpu_prog_loader: boot loader for the cpu core.
// It accepts a 32-bit valid/ready word stream. The first cfg_imem_words
// words go to instruction memory through ext port 1, one 32-bit write per
// word. The remaining words are paired into 64-bit data-memory writes
// through ext port 2, low beat first. After loading, cpu_enable is held
// high for cfg_run_cycles cycles.
// Optional feature: define LOADER_CHECKSUM_EN to add a 32-bit running sum of
// the accepted stream words on the checksum output.
module cpu_prog_loader #(
  parameter int IMEM_AW = 9,
  parameter int DMEM_AW = 10,
  parameter int RUN_W   = 32
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               start,
  input  logic [IMEM_AW:0]   cfg_imem_words,
  input  logic [DMEM_AW:0]   cfg_dmem_words,
  input  logic [RUN_W-1:0]   cfg_run_cycles,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [31:0]        s_data,
  input  logic               s_last,
  output logic [63:0]        addr_ext,
  output logic               wen_ext,
  output logic               ren_ext,
  output logic [31:0]        wdata_ext,
  output logic [63:0]        addr_ext_2,
  output logic               wen_ext_2,
  output logic               ren_ext_2,
  output logic [63:0]        wdata_ext_2,
  output logic               cpu_enable,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]        checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_I    = 3'd1,
    LOAD_D_LO = 3'd2,
    LOAD_D_HI = 3'd3,
    RUN       = 3'd4
  } state_e;

  state_e             state;
  logic [IMEM_AW:0]   cfg_imem_q;
  logic [DMEM_AW:0]   cfg_dmem_q;
  logic [RUN_W-1:0]   cfg_run_q;
  logic [IMEM_AW-1:0] i_idx;
  logic [DMEM_AW-1:0] d_idx;
  logic [31:0]        lo_q;
  logic [RUN_W-1:0]   run_cnt;

  logic hs;
  logic i_final;
  logic d_final;
  logic dmem_zero;
  logic expect_last;
  logic frame_err;

  // The loader never reads memory.
  assign ren_ext   = 1'b0;
  assign ren_ext_2 = 1'b0;

  assign hs        = s_valid & s_ready;
  assign i_final   = ({1'b0, i_idx} == cfg_imem_q - (IMEM_AW+1)'(1));
  assign d_final   = ({1'b0, d_idx} == cfg_dmem_q - (DMEM_AW+1)'(1));
  assign dmem_zero = (cfg_dmem_q == '0);

  // s_last is expected only on the image's final word. That is the last
  // imem word when there is no data image, otherwise the final high beat.
  always_comb begin
    expect_last = 1'b0;
    case (state)
      LOAD_I:    expect_last = i_final & dmem_zero;
      LOAD_D_HI: expect_last = d_final;
      default:   expect_last = 1'b0;
    endcase
  end

  assign frame_err = hs & (s_last != expect_last);

  // Main FSM. All outputs are registered here.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      cfg_imem_q  <= '0;
      cfg_dmem_q  <= '0;
      cfg_run_q   <= '0;
      i_idx       <= '0;
      d_idx       <= '0;
      lo_q        <= '0;
      run_cnt     <= '0;
      s_ready     <= 1'b0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      cpu_enable  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // NOTE: non-blocking updates with strobes defaulted low. Every branch
      // below sees last cycle's state, and each wen/done is a one-cycle pulse.
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      done      <= 1'b0;
      if (frame_err) begin
        // Bad framing: the offending word is not written and RUN is skipped.
        err     <= 1'b1;
        s_ready <= 1'b0;
        busy    <= 1'b0;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (cfg_imem_words == '0) begin
                err <= 1'b1;
              end else begin
                cfg_imem_q <= cfg_imem_words;
                cfg_dmem_q <= cfg_dmem_words;
                cfg_run_q  <= cfg_run_cycles;
                err        <= 1'b0;
                i_idx      <= '0;
                d_idx      <= '0;
                s_ready    <= 1'b1;
                busy       <= 1'b1;
                state      <= LOAD_I;
              end
            end
          end
          LOAD_I: begin
            if (hs) begin
              wen_ext   <= 1'b1;
              addr_ext  <= {{(62-IMEM_AW){1'b0}}, i_idx, 2'b00};
              wdata_ext <= s_data;
              if (!i_final) begin
                i_idx <= i_idx + IMEM_AW'(1);
              end else if (dmem_zero) begin
                s_ready <= 1'b0;
                run_cnt <= cfg_run_q;
                state   <= RUN;
              end else begin
                state <= LOAD_D_LO;
              end
            end
          end
          LOAD_D_LO: begin
            if (hs) begin
              lo_q  <= s_data;
              state <= LOAD_D_HI;
            end
          end
          LOAD_D_HI: begin
            if (hs) begin
              wen_ext_2   <= 1'b1;
              addr_ext_2  <= {{(61-DMEM_AW){1'b0}}, d_idx, 3'b000};
              wdata_ext_2 <= {s_data, lo_q};
              if (d_final) begin
                s_ready <= 1'b0;
                run_cnt <= cfg_run_q;
                state   <= RUN;
              end else begin
                d_idx <= d_idx + DMEM_AW'(1);
                state <= LOAD_D_LO;
              end
            end
          end
          RUN: begin
            // The first RUN cycle coincides with the final write pulse.
            // Enable therefore rises one cycle later and stays high
            // for run_cnt cycles.
            if (run_cnt == '0) begin
              cpu_enable <= 1'b0;
              done       <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              cpu_enable <= 1'b1;
              run_cnt    <= run_cnt - RUN_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of accepted words. It is cleared by an accepted start and
  // holds its value outside the load states because s_ready is low there.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      checksum <= '0;
    end else if (state == IDLE && start && cfg_imem_words != '0) begin
      checksum <= '0;
    end else if (hs) begin
      checksum <= checksum + s_data;
    end
  end
`endif

endmodule
